// File: rtl/peri_apb_arb.sv
// Two-master, one-slave APB arbiter for the peripheral register port.
// Round-robin grant, latched transfer fields, optional hung-slave timeout.
module peri_apb_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int TO_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    m0_psel,
    input  logic                    m0_penable,
    input  logic [ADDR_WIDTH-1:0]   m0_paddr,
    input  logic                    m0_pwrite,
    input  logic [DATA_WIDTH-1:0]   m0_pwdata,
    input  logic [DATA_WIDTH/8-1:0] m0_pstrb,
    input  logic [2:0]              m0_pprot,
    output logic [DATA_WIDTH-1:0]   m0_prdata,
    output logic                    m0_pready,
    output logic                    m0_pslverr,
    input  logic                    m1_psel,
    input  logic                    m1_penable,
    input  logic [ADDR_WIDTH-1:0]   m1_paddr,
    input  logic                    m1_pwrite,
    input  logic [DATA_WIDTH-1:0]   m1_pwdata,
    input  logic [DATA_WIDTH/8-1:0] m1_pstrb,
    input  logic [2:0]              m1_pprot,
    output logic [DATA_WIDTH-1:0]   m1_prdata,
    output logic                    m1_pready,
    output logic                    m1_pslverr,
    output logic                    s_psel,
    output logic                    s_penable,
    output logic                    s_pwrite,
    output logic [ADDR_WIDTH-1:0]   s_paddr,
    output logic [DATA_WIDTH-1:0]   s_pwdata,
    output logic [DATA_WIDTH/8-1:0] s_pstrb,
    output logic [2:0]              s_pprot,
    input  logic [DATA_WIDTH-1:0]   s_prdata,
    input  logic                    s_pready,
    input  logic                    s_pslverr
);

    // state  | meaning
    // IDLE   | arbitrate between m0/m1 requests, slave port idle
    // SETUP  | slave APB setup phase from latched fields
    // ACCESS | slave APB access phase, waiting on s_pready or timeout

    localparam int                STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit                TO_EN      = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LOAD  = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q;
    logic                    rr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [2:0]              prot_q;
    logic                    write_q;
    logic [TO_WIDTH-1:0]     cnt_q;

    logic                    any_req;
    logic                    win;
    logic                    done;
    logic                    abort;
    logic                    finish;
    logic                    resp_err;
    logic [DATA_WIDTH-1:0]   rdata;

    // penable is not part of the request qualification
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    always_comb begin
        any_req    = m0_psel | m1_psel;
        win        = (m0_psel && m1_psel) ? rr_q : m1_psel;
        done       = (state_q == ACCESS) && s_pready;
        abort      = TO_EN && (state_q == ACCESS) && !s_pready && (cnt_q == '0);
        finish     = done || abort;
        resp_err   = abort || s_pslverr;
        state_d    = state_q;

        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_psel     = (state_q != IDLE);
        s_penable  = (state_q == ACCESS);
        m0_pready  = finish && !grant_q;
        m1_pready  = finish && grant_q;
        m0_pslverr = m0_pready && resp_err;
        m1_pslverr = m1_pready && resp_err;
        // read data is only meaningful in ACCESS; holding it at 0 elsewhere
        // keeps every output at 0 while reset is asserted
        rdata      = ((state_q == ACCESS) && !abort) ? s_prdata : '0;
        m0_prdata  = rdata;
        m1_prdata  = rdata;
    end

    assign s_paddr  = addr_q;
    assign s_pwdata = wdata_q;
    assign s_pstrb  = strb_q;
    assign s_pprot  = prot_q;
    assign s_pwrite = write_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win;
                        addr_q  <= win ? m1_paddr  : m0_paddr;
                        wdata_q <= win ? m1_pwdata : m0_pwdata;
                        strb_q  <= win ? m1_pstrb  : m0_pstrb;
                        prot_q  <= win ? m1_pprot  : m0_pprot;
                        write_q <= win ? m1_pwrite : m0_pwrite;
                    end
                end
                SETUP: cnt_q <= TO_LOAD;
                ACCESS: begin
                    if (finish) begin
                        rr_q  <= ~grant_q;
                        cnt_q <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - TO_WIDTH'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peri_apb_arb.sv
// Directed bench for peri_apb_arb: scoreboarded master responses and slave
// transfers, plus latency, timeout, reset and no-timeout checks.
module tb_peri_apb_arb;

    localparam int NEVER = 32'h7fff_ffff;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } mexp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } sexp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // instance A: TIMEOUT=8
    logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m0_paddr, m0_pwdata, m1_paddr, m1_pwdata;
    logic [3:0]  m0_pstrb, m1_pstrb;
    logic [2:0]  m0_pprot, m1_pprot;
    logic [31:0] m0_prdata, m1_prdata;
    logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [31:0] s_paddr, s_pwdata, s_prdata;
    logic [3:0]  s_pstrb;
    logic [2:0]  s_pprot;

    // instance B: TIMEOUT=0
    logic        b_m0_psel, b_m0_penable, b_m0_pwrite, b_m1_psel, b_m1_penable, b_m1_pwrite;
    logic [31:0] b_m0_paddr, b_m0_pwdata, b_m1_paddr, b_m1_pwdata;
    logic [3:0]  b_m0_pstrb, b_m1_pstrb;
    logic [2:0]  b_m0_pprot, b_m1_pprot;
    logic [31:0] b_m0_prdata, b_m1_prdata;
    logic        b_m0_pready, b_m0_pslverr, b_m1_pready, b_m1_pslverr;
    logic        b_s_psel, b_s_penable, b_s_pwrite, b_s_pready, b_s_pslverr;
    logic [31:0] b_s_paddr, b_s_pwdata, b_s_prdata;
    logic [3:0]  b_s_pstrb;
    logic [2:0]  b_s_pprot;

    peri_apb_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8), .TO_WIDTH(9)) u_a (
        .clk(clk), .rstn(rstn),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
        .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
        .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
        .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
    );

    peri_apb_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0), .TO_WIDTH(9)) u_b (
        .clk(clk), .rstn(rstn),
        .m0_psel(b_m0_psel), .m0_penable(b_m0_penable), .m0_paddr(b_m0_paddr), .m0_pwrite(b_m0_pwrite),
        .m0_pwdata(b_m0_pwdata), .m0_pstrb(b_m0_pstrb), .m0_pprot(b_m0_pprot),
        .m0_prdata(b_m0_prdata), .m0_pready(b_m0_pready), .m0_pslverr(b_m0_pslverr),
        .m1_psel(b_m1_psel), .m1_penable(b_m1_penable), .m1_paddr(b_m1_paddr), .m1_pwrite(b_m1_pwrite),
        .m1_pwdata(b_m1_pwdata), .m1_pstrb(b_m1_pstrb), .m1_pprot(b_m1_pprot),
        .m1_prdata(b_m1_prdata), .m1_pready(b_m1_pready), .m1_pslverr(b_m1_pslverr),
        .s_psel(b_s_psel), .s_penable(b_s_penable), .s_pwrite(b_s_pwrite), .s_paddr(b_s_paddr),
        .s_pwdata(b_s_pwdata), .s_pstrb(b_s_pstrb), .s_pprot(b_s_pprot),
        .s_prdata(b_s_prdata), .s_pready(b_s_pready), .s_pslverr(b_s_pslverr)
    );

    // slave models: ready after slv_wait wait states in ACCESS
    int slv_wait = 0, slv_cnt = 0, b_slv_wait = 0, b_slv_cnt = 0;
    assign s_pready   = s_psel && s_penable && (slv_cnt >= slv_wait);
    assign b_s_pready = b_s_psel && b_s_penable && (b_slv_cnt >= b_slv_wait);
    always @(posedge clk) begin
        slv_cnt   <= (s_psel && s_penable && !s_pready) ? slv_cnt + 1 : 0;
        b_slv_cnt <= (b_s_psel && b_s_penable && !b_s_pready) ? b_slv_cnt + 1 : 0;
    end

    mexp_t mq0[$], mq1[$];
    sexp_t sq[$];
    int    n_chk = 0, n_err = 0, rc0 = 0, rc1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] strb_of(input int m);
        return (m == 0) ? 4'hF : 4'h3;
    endfunction

    function automatic logic [2:0] prot_of(input int m);
        return (m == 0) ? 3'b000 : 3'b101;
    endfunction

    task automatic req(input int m, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input bit push = 1'b1);
        mexp_t e;
        e = '{err: err, rd: !wr, data: rdata};
        if (m == 0) begin
            m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = wr; m0_paddr = addr;
            m0_pwdata = wdata; m0_pstrb = strb_of(0); m0_pprot = prot_of(0);
            if (push) mq0.push_back(e);
        end else begin
            m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = wr; m1_paddr = addr;
            m1_pwdata = wdata; m1_pstrb = strb_of(1); m1_pprot = prot_of(1);
            if (push) mq1.push_back(e);
        end
    endtask

    task automatic exp_slv(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        sq.push_back('{addr: addr, wr: wr, wdata: wdata, strb: strb_of(m), prot: prot_of(m)});
    endtask

    // one clock: sample at negedge, score responses/slave setups, advance masters
    task automatic cycle();
        mexp_t e;
        sexp_t se;
        @(negedge clk);
        if (m0_pready || m1_pready) chk("pready_excl", m0_pready & m1_pready, 1'b0);
        if (m0_psel && !m0_pready) chk("m0_pslverr_idle", m0_pslverr, 1'b0);
        if (m1_psel && !m1_pready) chk("m1_pslverr_idle", m1_pslverr, 1'b0);
        if (m0_pready) begin
            if (mq0.size() == 0) chk("m0_unexpected", m0_pready, 1'b0);
            else begin
                e = mq0.pop_front();
                chk("m0_pslverr", m0_pslverr, e.err);
                if (e.rd) chk("m0_prdata", m0_prdata, e.data);
            end
            rc0++; m0_psel = 1'b0; m0_penable = 1'b0;
        end else if (m0_psel && !m0_penable) m0_penable = 1'b1;
        if (m1_pready) begin
            if (mq1.size() == 0) chk("m1_unexpected", m1_pready, 1'b0);
            else begin
                e = mq1.pop_front();
                chk("m1_pslverr", m1_pslverr, e.err);
                if (e.rd) chk("m1_prdata", m1_prdata, e.data);
            end
            rc1++; m1_psel = 1'b0; m1_penable = 1'b0;
        end else if (m1_psel && !m1_penable) m1_penable = 1'b1;
        if (s_psel && !s_penable) begin
            if (sq.size() == 0) chk("s_unexpected", s_psel, 1'b0);
            else begin
                se = sq.pop_front();
                chk("s_paddr", s_paddr, se.addr);
                chk("s_pwrite", s_pwrite, se.wr);
                chk("s_pstrb", s_pstrb, se.strb);
                chk("s_pprot", s_pprot, se.prot);
                if (se.wr) chk("s_pwdata", s_pwdata, se.wdata);
            end
        end
    endtask

    task automatic wait_resp(input int m, input int budget);
        int target, n;
        target = ((m == 0) ? rc0 : rc1) + 1;
        n = 0;
        while (((m == 0) ? rc0 : rc1) < target && n < budget) begin
            cycle();
            n++;
        end
        chk($sformatf("wait_resp_m%0d", m), (((m == 0) ? rc0 : rc1) >= target), 1'b1);
    endtask

    task automatic idle_masters();
        m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0; m0_pstrb = 0; m0_pprot = 0;
        m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0; m1_pstrb = 0; m1_pprot = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_masters();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        idle_masters();
        b_m0_psel = 0; b_m0_penable = 0; b_m0_pwrite = 0; b_m0_paddr = 0; b_m0_pwdata = 0;
        b_m0_pstrb = 0; b_m0_pprot = 0;
        b_m1_psel = 0; b_m1_penable = 0; b_m1_pwrite = 0; b_m1_paddr = 0; b_m1_pwdata = 0;
        b_m1_pstrb = 0; b_m1_pprot = 0;
        s_prdata = 32'hA5A5_1234; s_pslverr = 1'b0;
        b_s_prdata = 32'h0; b_s_pslverr = 1'b0;

        // reset state, with a request present that must be ignored
        m0_psel = 1'b1; m0_paddr = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_s_psel", s_psel, 1'b0);
        chk("rst_s_penable", s_penable, 1'b0);
        chk("rst_s_paddr", s_paddr, 32'h0);
        chk("rst_m0_pready", m0_pready, 1'b0);
        chk("rst_m0_prdata", m0_prdata, 32'h0);
        chk("rst_m1_pslverr", m1_pslverr, 1'b0);
        chk("rst_b_s_psel", b_s_psel, 1'b0);
        m0_psel = 1'b0; m0_paddr = 32'h0;
        rstn = 1'b1;
        cycle();

        // 1: single zero-wait read from m0, latency T+1 / T+2
        req(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_1234);
        exp_slv(0, 1'b0, 32'h10, 32'h0);
        cycle();
        chk("t1_psel_T1", s_psel, 1'b1);
        chk("t1_penable_T1", s_penable, 1'b0);
        chk("t1_m0_pready_T1", m0_pready, 1'b0);
        cycle();
        chk("t1_penable_T2", s_penable, 1'b1);
        chk("t1_m0_pready_T2", m0_pready, 1'b1);
        chk("t1_m1_pready_T2", m1_pready, 1'b0);
        cycle();
        chk("t1_idle_after", s_psel, 1'b0);

        // 2: simultaneous writes after reset, then a second pair
        do_reset();
        req(0, 1'b1, 32'h04, 32'h11, 1'b0, 32'h0);
        req(1, 1'b1, 32'h08, 32'h22, 1'b0, 32'h0);
        exp_slv(0, 1'b1, 32'h04, 32'h11);
        exp_slv(1, 1'b1, 32'h08, 32'h22);
        wait_resp(0, 10);
        cycle();
        chk("t2_idle_gap", s_psel, 1'b0);
        chk("t2_m1_stalled", m1_pready, 1'b0);
        wait_resp(1, 10);
        req(0, 1'b1, 32'h0C, 32'h33, 1'b0, 32'h0);
        req(1, 1'b1, 32'h14, 32'h44, 1'b0, 32'h0);
        exp_slv(0, 1'b1, 32'h0C, 32'h33);
        exp_slv(1, 1'b1, 32'h14, 32'h44);
        wait_resp(0, 10);
        wait_resp(1, 10);
        cycle();

        // 3: m1 read, 5 wait states, slave error
        slv_wait = 5; s_pslverr = 1'b1; s_prdata = 32'hDEAD_BEEF;
        req(1, 1'b0, 32'h30, 32'h0, 1'b1, 32'hDEAD_BEEF);
        exp_slv(1, 1'b0, 32'h30, 32'h0);
        cycle();
        n = 0;
        do begin cycle(); n++; end while (!m1_pready && n < 20);
        chk("t3_m1_pready", m1_pready, 1'b1);
        chk("t3_access_cycles", n, 6);
        cycle();
        slv_wait = 0; s_pslverr = 1'b0;

        // 4: timeout abort of m0, pending m1 served after the IDLE cycle
        slv_wait = NEVER; s_prdata = 32'h1234_5678;
        req(0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0);
        req(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0BAD_F00D);
        exp_slv(0, 1'b0, 32'h20, 32'h0);
        exp_slv(1, 1'b0, 32'h24, 32'h0);
        cycle();
        n = 0;
        do begin cycle(); n++; end while (!m0_pready && n < 20);
        chk("t4_m0_pready", m0_pready, 1'b1);
        chk("t4_access_cycles", n, 8);
        cycle();
        chk("t4_psel_drop", s_psel, 1'b0);
        slv_wait = 0; s_prdata = 32'h0BAD_F00D;
        wait_resp(1, 10);
        cycle();

        // 5: make rr_ptr=1, reset mid-access of m1, then check rr_ptr restarts at 0
        req(0, 1'b1, 32'h40, 32'h55, 1'b0, 32'h0);
        exp_slv(0, 1'b1, 32'h40, 32'h55);
        wait_resp(0, 10);
        cycle();
        slv_wait = NEVER;
        req(1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0);
        exp_slv(1, 1'b0, 32'h44, 32'h0);
        n = 0;
        while (!s_penable && n < 10) begin cycle(); n++; end
        cycle();
        chk("t5_in_access", s_penable, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_s_psel", s_psel, 1'b0);
        chk("t5_rst_s_penable", s_penable, 1'b0);
        chk("t5_rst_m1_pready", m1_pready, 1'b0);
        chk("t5_rst_m1_prdata", m1_prdata, 32'h0);
        chk("t5_rst_s_paddr", s_paddr, 32'h0);
        idle_masters();
        slv_wait = 0;
        @(negedge clk);
        rstn = 1'b1;
        req(0, 1'b1, 32'h48, 32'h66, 1'b0, 32'h0);
        req(1, 1'b1, 32'h4C, 32'h77, 1'b0, 32'h0);
        exp_slv(0, 1'b1, 32'h48, 32'h66);
        exp_slv(1, 1'b1, 32'h4C, 32'h77);
        wait_resp(0, 10);
        wait_resp(1, 10);
        cycle();
        s_prdata = 32'h5050_5050;
        req(1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h5050_5050);
        exp_slv(1, 1'b0, 32'h50, 32'h0);
        wait_resp(1, 10);
        cycle();

        // 6: no-timeout instance, 1000 wait states
        b_slv_wait = 1000; b_s_pslverr = 1'b1; b_s_prdata = 32'h600D_CAFE;
        b_m0_psel = 1'b1; b_m0_penable = 1'b0; b_m0_pwrite = 1'b0; b_m0_paddr = 32'h60;
        n = 0;
        begin
            int acc;
            acc = 0;
            while (!b_m0_pready && n < 1200) begin
                @(negedge clk);
                n++;
                if (b_s_penable) acc++;
                b_m0_penable = 1'b1;
            end
            chk("t6_access_cycles", acc, 1001);
        end
        chk("t6_m0_pready", b_m0_pready, 1'b1);
        chk("t6_m0_pslverr", b_m0_pslverr, 1'b1);
        chk("t6_m0_prdata", b_m0_prdata, 32'h600D_CAFE);
        chk("t6_m1_pready", b_m1_pready, 1'b0);
        b_m0_psel = 1'b0; b_m0_penable = 1'b0;
        @(negedge clk);
        chk("t6_idle_after", b_s_psel, 1'b0);

        chk("sb_empty", mq0.size() + mq1.size() + sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
